belt_input_monitor: RTL and testbench
=====================================

# belt_input_monitor

Input-side front end of the seatbelt warning path. It synchronizes and debounces the raw ignition (KEY1), seat-occupancy (KEY0) and buckle (SW) inputs, then runs a grace-period state machine. Its outputs are a warning request level, a start pulse and an unbuckle event count. The LED flasher consumes `warn_req` and needs no raw-input decoding of its own.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000 (20 ms at 50 MHz): number of stable cycles required to accept a new input level; must be ≥2.
- `GRACE_CYCLES`, default 250000000 (5 s): number of cycles the warning condition must persist before a warning is raised; must be ≥2.
- `CLOCK_50` input 1: system clock; all logic is on its rising edge.
- `RST` input 1: reset, synchronous, active-low; clock CLOCK_50.
- `KEY1` input 1: raw ignition input, asynchronous; 1 = ignition on.
- `KEY0` input 1: raw seat input, asynchronous, active-low; 0 = seat occupied.
- `SW` input 1: raw buckle input, asynchronous; 1 = belt fastened.
- `ign_on` output 1: debounced ignition-on level.
- `seat_occ` output 1: debounced seat-occupied level.
- `belt_ok` output 1: debounced belt-fastened level.
- `warn_req` output 1: high for every cycle the FSM is in WARN.
- `warn_start` output 1: single-cycle pulse on the first WARN cycle.
- `unbuckle_count` output 8: saturating count of unbuckle events while the ignition is on.

## Operation
- Polarity is converted before synchronization: logical ign = KEY1, seat = ~KEY0, belt = SW. Each signal passes through a 2-flop synchronizer. Synchronizer flops reset to 0.
- Debounce operates per signal. A counter of width clog2(DEBOUNCE_CYCLES) clears whenever the synchronized value equals the debounced value. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value flips on the next edge and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- Condition C = ign_on & seat_occ & ~belt_ok, computed from the debounced registers.
- FSM states: OFF, RUN, GRACE, WARN. The reset state is OFF.
  - OFF: if ign_on and C, go to GRACE. If ign_on and not C, go to RUN.
  - RUN: if ~ign_on, go to OFF. Else if C, go to GRACE.
  - GRACE: the grace counter (width clog2(GRACE_CYCLES)) increments each cycle. If ~ign_on, go to OFF. Else if ~C, go to RUN. Else if the count equals GRACE_CYCLES-1, go to WARN. The grace counter clears on every exit from GRACE.
  - WARN: if ~ign_on, go to OFF. Else if ~C, go to RUN. Otherwise stay.
- Priority is ~ign_on first, then ~C, then grace expiry.
- `unbuckle_count` increments by 1 on a cycle where the debounced belt_ok is 1 and will become 0 on that edge, provided ign_on is 1 after that edge. The count saturates at 255 and is cleared only by reset.
- `warn_req` and `warn_start` are registered. They are decoded from the next state, so they align with the state register.

## Timing
- Reset: on a rising edge with RST=0, all of the following go to 0 on that edge: synchronizers, debounce counters, ign_on, seat_occ, belt_ok, grace counter, warn_req, warn_start and unbuckle_count. The FSM goes to OFF. Reset mid-WARN drops `warn_req` on that same edge.
- Input latency: for a clean raw step, the debounced output changes on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new level.
- When C becomes true, the FSM enters GRACE on the next edge. It remains in GRACE for exactly GRACE_CYCLES cycles and then enters WARN. `warn_start` is high for exactly that first WARN cycle.
- When C becomes false, or the ignition turns off, `warn_req` falls on the next edge. A later re-entry restarts the full grace period.
- Simultaneous events:
  - The ignition turning off on the same edge as belt_ok falling gives no count increment, and the FSM goes to OFF.
  - The belt being fastened on the same edge as grace expiry gives RUN, with no `warn_start`.

## Test plan
- DEBOUNCE_CYCLES=4, GRACE_CYCLES=10. Reset for 3 cycles, then release -> all outputs are 0 and the FSM is in OFF. Hold KEY1=1, KEY0=0, SW=0 -> ign_on, seat_occ and belt_ok settle after 6 cycles, and `warn_start` pulses exactly 11 cycles after C is first true. `warn_req` stays high afterwards.
- Toggle SW 1 for 3 cycles and back while in GRACE -> belt_ok never rises and the grace timing is unchanged.
- While in WARN, set SW=1 and hold it -> `warn_req` falls 7 cycles after the SW edge and the FSM is in RUN. Then set SW=0 -> `unbuckle_count` becomes 1, and a new full 10-cycle grace period runs before `warn_start`.
- Perform 300 unbuckle cycles with the ignition on -> `unbuckle_count` saturates at 255. Repeat with KEY1=0 -> no increment.
- Assert RST=0 for one edge mid-WARN -> `warn_req` and `unbuckle_count` are 0 on that edge, and re-warning requires the full debounce plus grace sequence.
- Bring SW and KEY1 low together while in RUN with belt_ok=1 -> FSM goes to OFF, `unbuckle_count` is unchanged, and `warn_start` never fires.

Source files
------------

// File: rtl/belt_input_monitor.sv
// belt_input_monitor: synchronizes and debounces ignition, seat and buckle
// inputs, then runs the grace-period FSM that requests the seatbelt warning
// and counts unbuckle events while the ignition is on.
module belt_input_monitor #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned GRACE_CYCLES    = 250000000
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       KEY1,
  input  logic       KEY0,
  input  logic       SW,
  output logic       ign_on,
  output logic       seat_occ,
  output logic       belt_ok,
  output logic       warn_req,
  output logic       warn_start,
  output logic [7:0] unbuckle_count
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned GW = $clog2(GRACE_CYCLES);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_GRACE = 2'd2;
  localparam logic [1:0] S_WARN  = 2'd3;

  // Channel index: 0 = ignition, 1 = seat occupied, 2 = belt fastened.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_nxt;
  logic [DW-1:0] db_cnt [3];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [GW-1:0] grace_cnt;
  logic          cond;

  assign raw = {SW, ~KEY0, KEY1};

  assign ign_on   = deb[0];
  assign seat_occ = deb[1];
  assign belt_ok  = deb[2];

  // Two-flop synchronizer per channel, polarity already normalized.
  always_ff @(posedge CLOCK_50) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounced value each channel takes on the coming edge.
  always_comb begin
    deb_nxt = deb;
    for (int unsigned i = 0; i < 3; i++) begin
      if ((sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST)) begin
        deb_nxt[i] = ~deb[i];
      end
    end
  end

  // Per-channel stability counter; the level is accepted after it runs out.
  always_ff @(posedge CLOCK_50) begin
    if (!RST) begin
      deb <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      deb <= deb_nxt;
      for (int unsigned i = 0; i < 3; i++) begin
        if ((sync2[i] == deb[i]) || (db_cnt[i] == DB_LAST)) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cond = deb[0] & deb[1] & ~deb[2];

  // Next-state logic: ignition off wins, then condition cleared, then expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF: begin
        if (deb[0]) state_nxt = cond ? S_GRACE : S_RUN;
      end
      S_RUN: begin
        if (!deb[0])   state_nxt = S_OFF;
        else if (cond) state_nxt = S_GRACE;
      end
      S_GRACE: begin
        if (!deb[0])                      state_nxt = S_OFF;
        else if (!cond)                   state_nxt = S_RUN;
        else if (grace_cnt == GRACE_LAST) state_nxt = S_WARN;
      end
      default: begin
        if (!deb[0])    state_nxt = S_OFF;
        else if (!cond) state_nxt = S_RUN;
      end
    endcase
  end

  // State, grace timer and registered warning outputs decoded from next state.
  always_ff @(posedge CLOCK_50) begin
    if (!RST) begin
      state      <= S_OFF;
      grace_cnt  <= '0;
      warn_req   <= 1'b0;
      warn_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      grace_cnt  <= ((state == S_GRACE) && (state_nxt == S_GRACE)) ?
                    grace_cnt + 1'b1 : '0;
      warn_req   <= (state_nxt == S_WARN);
      warn_start <= (state_nxt == S_WARN) && (state != S_WARN);
    end
  end

  // Count belt releases that leave the ignition on after the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (!RST) begin
      unbuckle_count <= '0;
    end else if (deb[2] && !deb_nxt[2] && deb_nxt[0] &&
                 (unbuckle_count != 8'hFF)) begin
      unbuckle_count <= unbuckle_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_belt_input_monitor.sv
// Directed bench for belt_input_monitor with a scoreboard of expected
// warn_start pulse cycles.
module tb_belt_input_monitor;

  localparam logic [1:0] T_OFF   = 2'd0;
  localparam logic [1:0] T_RUN   = 2'd1;
  localparam logic [1:0] T_GRACE = 2'd2;
  localparam logic [1:0] T_WARN  = 2'd3;

  logic       CLOCK_50 = 1'b0;
  logic       RST;
  logic       KEY1;
  logic       KEY0;
  logic       SW;
  logic       ign_on;
  logic       seat_occ;
  logic       belt_ok;
  logic       warn_req;
  logic       warn_start;
  logic [7:0] unbuckle_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned base;
  int unsigned exp_cnt;
  int unsigned sb [$];

  belt_input_monitor #(
    .DEBOUNCE_CYCLES(4),
    .GRACE_CYCLES(10)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST(RST),
    .KEY1(KEY1),
    .KEY0(KEY0),
    .SW(SW),
    .ign_on(ign_on),
    .seat_occ(seat_occ),
    .belt_ok(belt_ok),
    .warn_req(warn_req),
    .warn_start(warn_start),
    .unbuckle_count(unbuckle_count)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Every warn_start pulse must match the oldest expected pulse cycle.
  always @(negedge CLOCK_50) begin
    if (warn_start === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_warn_start", cyc, 0);
      end else begin
        chk("warn_start_cycle", cyc, sb.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b0; KEY1 = 1'b0; KEY0 = 1'b1; SW = 1'b0;
    tick(3);
    RST = 1'b1;
    chk("rst_ign", ign_on, 0);
    chk("rst_seat", seat_occ, 0);
    chk("rst_belt", belt_ok, 0);
    chk("rst_warn_req", warn_req, 0);
    chk("rst_warn_start", warn_start, 0);
    chk("rst_count", unbuckle_count, 0);
    chk("rst_state", dut.state, T_OFF);
    tick(1);
    chk("idle_state", dut.state, T_OFF);

    // Ignition on, seat occupied, belt open.
    KEY1 = 1'b1; KEY0 = 1'b0; base = cyc; sb.push_back(base + 17);
    tick(5);
    chk("ign_before_debounce", ign_on, 0);
    tick(1);
    chk("ign_settled", ign_on, 1);
    chk("seat_settled", seat_occ, 1);
    chk("belt_still_open", belt_ok, 0);
    tick(1);
    chk("state_grace", dut.state, T_GRACE);

    // Three-cycle buckle glitch inside the grace period.
    tick(1);
    SW = 1'b1;
    tick(3);
    SW = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("glitch_belt", belt_ok, 0);
      chk("grace_no_warn", warn_req, 0);
    end
    tick(1);
    chk("warn_req_rise", warn_req, 1);
    chk("state_warn", dut.state, T_WARN);
    tick(3);
    chk("warn_req_hold", warn_req, 1);
    chk("warn_start_single", warn_start, 0);

    // Fasten belt while warning, then release it.
    SW = 1'b1;
    tick(6);
    chk("belt_rise", belt_ok, 1);
    chk("warn_req_before_fall", warn_req, 1);
    tick(1);
    chk("warn_req_fall", warn_req, 0);
    chk("state_run", dut.state, T_RUN);
    SW = 1'b0; base = cyc; sb.push_back(base + 17);
    tick(5);
    chk("count_before_fall", unbuckle_count, 0);
    tick(1);
    chk("count_first", unbuckle_count, 1);
    tick(10);
    chk("regrace_no_warn", warn_req, 0);
    tick(1);
    chk("regrace_warn", warn_req, 1);

    // Ignition off: unbuckles are not counted.
    KEY1 = 1'b0;
    tick(6);
    chk("ign_off", ign_on, 0);
    tick(1);
    chk("state_off", dut.state, T_OFF);
    chk("warn_req_ign_off", warn_req, 0);
    for (int i = 0; i < 5; i++) begin
      SW = 1'b1; tick(6);
      SW = 1'b0; tick(6);
      chk("count_ign_off", unbuckle_count, 1);
    end
    SW = 1'b1; tick(6);
    KEY1 = 1'b1; tick(7);
    chk("ign_back", ign_on, 1);
    chk("state_run_again", dut.state, T_RUN);

    // Repeated unbuckles with ignition on saturate the counter.
    exp_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      SW = 1'b0; tick(6);
      SW = 1'b1; tick(6);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      chk("count_sat", unbuckle_count, exp_cnt);
    end
    tick(2);
    chk("state_run_after_sat", dut.state, T_RUN);

    // Reset during WARN, then full re-warn sequence.
    SW = 1'b0; base = cyc; sb.push_back(base + 17);
    tick(19);
    chk("warn_before_reset", warn_req, 1);
    RST = 1'b0;
    tick(1);
    RST = 1'b1;
    chk("reset_warn_req", warn_req, 0);
    chk("reset_count", unbuckle_count, 0);
    chk("reset_state", dut.state, T_OFF);
    chk("reset_ign", ign_on, 0);
    base = cyc; sb.push_back(base + 17);
    tick(16);
    chk("rewarn_not_yet", warn_req, 0);
    tick(1);
    chk("rewarn", warn_req, 1);

    // Belt released and ignition off on the same edge.
    SW = 1'b1;
    tick(7);
    chk("run_before_simul", dut.state, T_RUN);
    chk("belt_before_simul", belt_ok, 1);
    chk("warn_req_before_simul", warn_req, 0);
    KEY1 = 1'b0; SW = 1'b0;
    tick(6);
    chk("simul_ign", ign_on, 0);
    chk("simul_belt", belt_ok, 0);
    chk("simul_count", unbuckle_count, 0);
    tick(1);
    chk("simul_state_off", dut.state, T_OFF);
    tick(20);
    chk("simul_count_final", unbuckle_count, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
